rf_rw: RTL and testbench



---
 rtl/rf_rw.sv | 72 +++++++
 tb/tb_rf_rw.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rf_rw.sv
// 32 x DATA_W MIPS register file: two combinational read ports, one clocked write port, R0 hardwired to 0.
// Read latency 0, write latency 1 edge; always accepts a write, no backpressure; optional same-cycle write bypass.
module rf_rw #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        Src1addr,
  input  logic [4:0]        Src2addr,
  output logic [DATA_W-1:0] Src1,
  output logic [DATA_W-1:0] Src2,
  input  logic              WEn,
  input  logic [4:0]        Dstaddr,
  input  logic [DATA_W-1:0] Dstdata,
  output logic [CNT_W-1:0]  WrCnt
);

  logic [DATA_W-1:0] r_regs [1:31];
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              w_commit;
  logic              w_byp1;
  logic              w_byp2;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;

  assign w_commit = WEn && (Dstaddr != 5'd0);

  // Reset image R[i] = i keeps older benches that assumed fixed register contents working.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
    end else if (w_commit) begin
      r_regs[Dstaddr] <= Dstdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_commit) begin
      r_wr_cnt <= r_wr_cnt + CNT_W'(1);
    end
  end

  assign w_byp1 = (BYPASS != 0) && WEn && (Dstaddr == Src1addr);
  assign w_byp2 = (BYPASS != 0) && WEn && (Dstaddr == Src2addr);

  always_comb begin
    w_src1 = '0;
    if (Src1addr != 5'd0) begin
      if (w_byp1) w_src1 = Dstdata;
      else        w_src1 = r_regs[Src1addr];
    end
  end

  always_comb begin
    w_src2 = '0;
    if (Src2addr != 5'd0) begin
      if (w_byp2) w_src2 = Dstdata;
      else        w_src2 = r_regs[Src2addr];
    end
  end

  assign Src1  = w_src1;
  assign Src2  = w_src2;
  assign WrCnt = r_wr_cnt;

endmodule

// File: tb/tb_rf_rw.sv
// Self-checking bench for rf_rw: bypass and non-bypass instances share stimulus, checked against a reference model.
module tb_rf_rw;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Src1addr;
  logic [4:0]  Src2addr;
  logic        WEn;
  logic [4:0]  Dstaddr;
  logic [31:0] Dstdata;
  logic [31:0] src1_b, src2_b, src1_n, src2_n;
  logic [15:0] cnt_b, cnt_n;

  rf_rw #(.DATA_W(32), .BYPASS(1), .CNT_W(16)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .Src1addr(Src1addr), .Src2addr(Src2addr),
    .Src1(src1_b), .Src2(src2_b), .WEn(WEn), .Dstaddr(Dstaddr),
    .Dstdata(Dstdata), .WrCnt(cnt_b)
  );

  rf_rw #(.DATA_W(32), .BYPASS(0), .CNT_W(16)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .Src1addr(Src1addr), .Src2addr(Src2addr),
    .Src1(src1_n), .Src2(src2_n), .WEn(WEn), .Dstaddr(Dstaddr),
    .Dstdata(Dstdata), .WrCnt(cnt_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model
  logic [31:0] m_regs [0:31];
  logic [15:0] m_cnt;
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    m_cnt = 16'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && WEn && Dstaddr == a) return Dstdata;
    return m_regs[a];
  endfunction

  // Called right after each rising edge, mirroring what the DUT sampled there.
  task automatic model_edge();
    if (rst_n && WEn && Dstaddr != 5'd0) begin
      m_regs[Dstaddr] = Dstdata;
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic expect_reads(input string tag);
    exp_q.push_back(model_read(Src1addr, 1'b1)); tag_q.push_back({tag, "_b_src1"});
    exp_q.push_back(model_read(Src2addr, 1'b1)); tag_q.push_back({tag, "_b_src2"});
    exp_q.push_back(model_read(Src1addr, 1'b0)); tag_q.push_back({tag, "_n_src1"});
    exp_q.push_back(model_read(Src2addr, 1'b0)); tag_q.push_back({tag, "_n_src2"});
  endtask

  task automatic compare_reads();
    logic [31:0] obs [4];
    #1;
    obs[0] = src1_b; obs[1] = src2_b; obs[2] = src1_n; obs[3] = src2_n;
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry");
      end else begin
        check_eq(tag_q.pop_front(), obs[i], exp_q.pop_front());
      end
    end
  endtask

  task automatic read_check(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    Src1addr = a1;
    Src2addr = a2;
    expect_reads(tag);
    compare_reads();
  endtask

  task automatic check_cnt(input string tag);
    #1;
    check_eq({tag, "_cnt_b"}, 32'(cnt_b), 32'(m_cnt));
    check_eq({tag, "_cnt_n"}, 32'(cnt_n), 32'(m_cnt));
  endtask

  // Called just after a falling edge; returns just after the next falling edge with WEn low.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    WEn = 1'b1; Dstaddr = a; Dstdata = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    WEn = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; WEn = 1'b0; Dstaddr = '0; Dstdata = '0;
    Src1addr = '0; Src2addr = '0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Reset image sweep
    check_cnt("reset");
    for (int i = 0; i < 32; i++) read_check(5'(i), 5'(31 - i), $sformatf("reset_img%0d", i));

    // Basic write/read
    do_write(5'd5, 32'hDEADBEEF);
    read_check(5'd5, 5'd6, "basic");
    check_cnt("basic");

    // Zero register: during and after the edge
    WEn = 1'b1; Dstaddr = 5'd0; Dstdata = 32'hFFFFFFFF;
    read_check(5'd0, 5'd0, "zero_pre");
    @(posedge clk); model_edge(); @(negedge clk); WEn = 1'b0;
    read_check(5'd0, 5'd0, "zero_post");
    check_cnt("zero");

    // Bypass vs non-bypass in the write cycle, then both after the edge
    WEn = 1'b1; Dstaddr = 5'd9; Dstdata = 32'h12345678;
    read_check(5'd9, 5'd9, "byp_pre");
    @(posedge clk); model_edge(); @(negedge clk); WEn = 1'b0;
    read_check(5'd9, 5'd9, "byp_post");

    // Back-to-back writes to one index: last wins
    WEn = 1'b1; Dstaddr = 5'd3; Dstdata = 32'h11111111;
    @(posedge clk); model_edge(); #1;
    Dstdata = 32'h22222222;
    @(posedge clk); model_edge(); @(negedge clk); WEn = 1'b0;
    read_check(5'd3, 5'd5, "b2b");
    check_cnt("b2b");

    // Reset mid-operation
    do_write(5'd17, 32'hAAAA5555);
    read_check(5'd17, 5'd9, "pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    read_check(5'd17, 5'd9, "in_rst");
    check_cnt("in_rst");
    WEn = 1'b1; Dstaddr = 5'd17; Dstdata = 32'hCAFEF00D;
    @(posedge clk); model_edge(); @(negedge clk);
    WEn = 1'b0;
    #2 rst_n = 1'b1;
    read_check(5'd17, 5'd1, "rst_lost_wr");
    check_cnt("rst_lost_wr");
    @(negedge clk);

    // Counter wrap over 65536 commits to rotating nonzero addresses
    for (int k = 0; k < 65536; k++) begin
      do_write(5'((k % 31) + 1), (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000);
      if (k == 65534) check_cnt("cnt_ffff");
    end
    check_cnt("cnt_wrap");
    for (int i = 1; i < 32; i++) read_check(5'(i), 5'(32 - i), $sformatf("wrap_rd%0d", i));

    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
